// File: rtl/carregador_cromossomo.sv
// Byte-stream loader for the 330-bit chromosome: bytes are packed LSB-first into a
// shadow register and committed to `cromossomo` in a single cycle once the frame is complete.
module carregador_cromossomo #(
  parameter int CHROM_WIDTH    = 330,
  parameter int BYTE_COUNT     = 42,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [CHROM_WIDTH-1:0] cromossomo,
  output logic                   chrom_valid,
  output logic                   commit_pulse,
  output logic                   frame_abort,
  output logic                   busy
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready is high only in LOAD and drops whenever frame_start is asserted.

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [5:0]    LAST_BYTE = 6'(BYTE_COUNT - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [5:0]             count, count_next;
  logic [TW-1:0]          timer, timer_next;
  logic [CHROM_WIDTH-1:0] shadow, shadow_next;
  logic                   abort;
  logic                   accept;

  always_comb begin
    state_next  = state;
    count_next  = count;
    timer_next  = timer;
    shadow_next = shadow;
    abort       = 1'b0;
    accept      = 1'b0;
    byte_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_next  = LOAD;
          count_next  = '0;
          timer_next  = '0;
          shadow_next = '0;
        end
      end
      LOAD: begin
        byte_ready = !frame_start;
        accept     = byte_valid && !frame_start;
        if (frame_start) begin
          count_next  = '0;
          timer_next  = '0;
          shadow_next = '0;
          abort       = 1'b1;
        end else if (accept) begin
          // Shadow is cleared at frame start, so OR-ing each byte into place is enough;
          // bits shifted past CHROM_WIDTH fall off the top.
          shadow_next = shadow | (CHROM_WIDTH'(byte_in) << {count, 3'b000});
          timer_next  = '0;
          if (count == LAST_BYTE) begin
            state_next = COMMIT;
            count_next = '0;
          end else begin
            count_next = count + 6'd1;
          end
        end else if (timer == TIMER_MAX) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      timer        <= '0;
      shadow       <= '0;
      cromossomo   <= '0;
      chrom_valid  <= 1'b0;
      commit_pulse <= 1'b0;
      frame_abort  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      timer        <= timer_next;
      shadow       <= shadow_next;
      busy         <= (state_next != IDLE);
      frame_abort  <= abort;
      commit_pulse <= (state == COMMIT);
      if (state == COMMIT) begin
        cromossomo  <= shadow;
        chrom_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_carregador_cromossomo.sv
// Directed bench for carregador_cromossomo: framing, gaps, restart, timeout and async reset,
// with a byte-queue model producing the expected chromosome of each committed frame.
module tb_carregador_cromossomo;

  localparam int W  = 330;
  localparam int BC = 42;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_start = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic         byte_valid = 1'b0;
  logic         byte_ready;
  logic [W-1:0] cromossomo;
  logic         chrom_valid;
  logic         commit_pulse;
  logic         frame_abort;
  logic         busy;

  int           n_vec  = 0;
  int           n_fail = 0;
  logic [7:0]   exp_q[$];
  logic [W-1:0] ones;
  logic [W-1:0] a5_pat;
  logic [W-1:0] ramp_val;

  carregador_cromossomo #(
    .CHROM_WIDTH   (W),
    .BYTE_COUNT    (BC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .cromossomo  (cromossomo),
    .chrom_valid (chrom_valid),
    .commit_pulse(commit_pulse),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [W-1:0] model_chrom();
    logic [W-1:0] m;
    m = '0;
    for (int k = 0; k < exp_q.size(); k++) begin
      for (int b = 0; b < 8; b++) begin
        if (8 * k + b < W) m[8 * k + b] = exp_q[k][b];
      end
    end
    return m;
  endfunction

  // Called at a falling edge; leaves frame_start low and busy checked one edge later.
  task automatic start_frame(input string tag);
    frame_start = 1'b1;
    byte_valid  = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1'b1);
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    byte_in    = 8'hEE;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    #1;
    check("byte_ready_in_load", byte_ready, 1'b1);
    @(negedge clk);
    exp_q.push_back(b);
  endtask

  // Called at the falling edge right after the last byte's accept edge.
  task automatic finish_frame(input string tag);
    byte_valid = 1'b0;
    check({tag, "_busy_in_commit"}, busy, 1'b1);
    check({tag, "_no_early_pulse"}, commit_pulse, 1'b0);
    @(negedge clk);
    check({tag, "_commit_pulse"}, commit_pulse, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_chrom_valid"}, chrom_valid, 1'b1);
    check({tag, "_cromossomo"}, cromossomo, model_chrom());
    @(negedge clk);
    check({tag, "_pulse_single"}, commit_pulse, 1'b0);
  endtask

  initial begin
    ones   = '1;
    a5_pat = {2'b01, {41{8'hA5}}};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cromossomo", cromossomo, '0);
    check("rst_chrom_valid", chrom_valid, 1'b0);
    check("rst_commit_pulse", commit_pulse, 1'b0);
    check("rst_frame_abort", frame_abort, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_byte_ready", byte_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // IDLE ignores bytes
    for (int i = 0; i < 8; i++) begin
      byte_valid = (i % 2 == 0);
      byte_in    = 8'($urandom_range(0, 255));
      #1;
      check("idle_byte_ready", byte_ready, 1'b0);
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
    end
    byte_valid = 1'b0;

    // Timeout: abort 16 cycles after the last accept
    start_frame("to");
    for (int k = 0; k < 5; k++) send_byte(8'(k + 1), 0);
    byte_valid = 1'b0;
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      check("to_no_abort_yet", frame_abort, 1'b0);
    end
    @(negedge clk);
    check("to_abort", frame_abort, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_cromossomo", cromossomo, '0);
    check("to_chrom_valid", chrom_valid, 1'b0);
    @(negedge clk);
    check("to_abort_single", frame_abort, 1'b0);

    // Ramp frame back-to-back
    start_frame("ramp");
    for (int k = 0; k < BC; k++) send_byte(8'(k), 0);
    finish_frame("ramp");
    check("ramp_b0", cromossomo[7:0], 8'h00);
    check("ramp_b1", cromossomo[15:8], 8'h01);
    check("ramp_b40", cromossomo[327:320], 8'h28);
    check("ramp_top", cromossomo[329:328], 2'b01);
    ramp_val = cromossomo;

    // Same ramp with byte_valid gaps; gap bytes carry 0xEE
    start_frame("gap");
    for (int k = 0; k < BC; k++) send_byte(8'(k), (k % 3 == 1) ? 1 : ((k % 5 == 0) ? 2 : 0));
    finish_frame("gap");
    check("gap_same_as_ramp", cromossomo, ramp_val);

    // All-ones frame, then a restarted frame
    start_frame("ff");
    for (int k = 0; k < BC; k++) send_byte(8'hFF, 0);
    finish_frame("ff");
    check("ff_all_ones", cromossomo, ones);

    start_frame("rs");
    for (int k = 0; k < 10; k++) send_byte(8'h00, 0);
    frame_start = 1'b1;
    byte_valid  = 1'b1;
    byte_in     = 8'h77;
    #1;
    check("rs_byte_ready_low", byte_ready, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    check("rs_abort", frame_abort, 1'b1);
    check("rs_busy", busy, 1'b1);
    check("rs_crom_kept", cromossomo, ones);
    exp_q.delete();
    @(negedge clk);
    check("rs_abort_single", frame_abort, 1'b0);
    for (int k = 0; k < BC; k++) send_byte(8'hA5, 0);
    finish_frame("a5");
    check("a5_pattern", cromossomo, a5_pat);

    // Async reset mid-frame, then a fresh frame
    start_frame("ar");
    for (int k = 0; k <= 20; k++) send_byte(8'($urandom_range(0, 255)), 0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_cromossomo", cromossomo, '0);
    check("ar_chrom_valid", chrom_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_byte_ready", byte_ready, 1'b0);
    check("ar_commit_pulse", commit_pulse, 1'b0);
    check("ar_frame_abort", frame_abort, 1'b0);
    @(negedge clk);
    rst        = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    start_frame("post");
    for (int k = 0; k < BC; k++) send_byte(8'($urandom_range(0, 255)), 0);
    finish_frame("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
